// File: rtl/alu_issue_ctrl_if.sv
// Request/response and ALU-side signal bundle for the ALU issue controller.
// The slave modport is the controller; the master modport is its environment.
interface alu_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  // Request port
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_use_acc;

  // ALU operand/result side
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_s;
  logic [DW-1:0] alu_acc;
  logic [DW-1:0] alu_mulh;
  logic [DW-1:0] alu_flag;

  // Response port and status
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_result;
  logic [DW-1:0]    rsp_mulh;
  logic [DW-1:0]    rsp_flag;
  logic [DW-1:0]    acc_q;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_use_acc,
    input  alu_acc, alu_mulh, alu_flag,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_s,
    output rsp_valid, rsp_result, rsp_mulh, rsp_flag, acc_q, op_count
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_use_acc,
    output alu_acc, alu_mulh, alu_flag,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_s,
    input  rsp_valid, rsp_result, rsp_mulh, rsp_flag, acc_q, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of an 8-bit combinational ALU: registers a request onto
// the ALU inputs, captures the ALU outputs one cycle later, and holds the result on
// a valid/ready response port and in an accumulator that later requests can chain from.
module alu_issue_ctrl #(
  parameter logic [7:0]  ACC_INIT = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam logic [SW-1:0] OP_MUL = SW'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_rsp_done;

  logic [DW-1:0]    r_alu_a;
  logic [DW-1:0]    r_alu_b;
  logic [SW-1:0]    r_alu_s;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_result;
  logic [DW-1:0]    r_rsp_mulh;
  logic [DW-1:0]    r_rsp_flag;
  logic [DW-1:0]    r_acc;
  logic [CNT_W-1:0] r_op_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshake decode; ready never looks at req_valid
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        w_req_ready = bus.rsp_ready;
        w_rsp_done  = bus.rsp_ready;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_accept = bus.req_valid & w_req_ready;
    if (w_accept)                 w_state_nxt = EXEC;
    else if (w_rsp_done)          w_state_nxt = IDLE;
  end

  // Operand/opcode registers driving the ALU; held outside of an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_s <= '0;
    end else if (w_accept) begin
      r_alu_a <= bus.req_use_acc ? r_acc : bus.req_a;
      r_alu_b <= bus.req_b;
      r_alu_s <= bus.req_op;
    end
  end

  // Response capture after the ALU has settled for a full cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= '0;
      r_rsp_mulh   <= '0;
      r_rsp_flag   <= '0;
      r_acc        <= ACC_INIT;
    end else if (w_capture) begin
      r_rsp_result <= bus.alu_acc;
      r_rsp_mulh   <= (r_alu_s == OP_MUL) ? bus.alu_mulh : '0;
      r_rsp_flag   <= bus.alu_flag;
      r_acc        <= bus.alu_acc;
    end
  end

  // Response valid: set on capture, cleared when the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_rsp_valid <= 1'b0;
    else if (w_capture)  r_rsp_valid <= 1'b1;
    else if (w_rsp_done) r_rsp_valid <= 1'b0;
  end

  // Saturating count of completed operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_capture && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_s      = r_alu_s;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_mulh   = r_rsp_mulh;
  assign bus.rsp_flag   = r_rsp_flag;
  assign bus.acc_q      = r_acc;
  assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  localparam int unsigned CNT_W    = 16;
  localparam logic [7:0]  ACC_INIT = 8'hA5;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   cyc;

  alu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  alu_issue_ctrl #(.ACC_INIT(ACC_INIT), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {acc, mulh, flag}. flag[0]=zero, [1]=sign, [4]=add carry, [5]=sub no-borrow
  function automatic logic [23:0] alu_fn(input logic [2:0] s, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0]  sum;
    logic [15:0] prod;
    logic [7:0]  r;
    logic [7:0]  f;
    sum  = 9'(a) + 9'(b);
    prod = 16'(a) * 16'(b);
    case (s)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~a;
      3'd3:    r = a << b[2:0];
      3'd4:    r = a >> b[2:0];
      3'd5:    r = sum[7:0];
      3'd6:    r = a - b;
      default: r = prod[7:0];
    endcase
    f    = 8'h00;
    f[0] = (r == 8'h00);
    f[1] = r[7];
    if (s == 3'd5) f[4] = sum[8];
    if (s == 3'd6) f[5] = (a >= b);
    return {r, prod[15:8], f};
  endfunction

  assign {bus.alu_acc, bus.alu_mulh, bus.alu_flag} = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [7:0]       res;
    logic [7:0]       mulh;
    logic [7:0]       flag;
    logic [CNT_W-1:0] cnt;
    int               stamp;
    bit               seen;
  } exp_t;

  exp_t             sb[$];
  logic [7:0]       m_acc;
  logic [CNT_W-1:0] m_cnt;

  // Scoreboard: push on accept, compare while a response is held, pop when it leaves
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] a_op;
    logic [23:0] r;
    cyc++;
    if (rst_n) begin
      if (sb.size() == 0) begin
        check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
        check("acc_idle", 32'(bus.acc_q), 32'(m_acc));
      end else begin
        if (!sb[0].seen) begin
          if (bus.rsp_valid || (cyc - sb[0].stamp >= 2)) begin
            check("latency", 32'(cyc - sb[0].stamp), 32'd2);
            sb[0].seen = 1'b1;
          end
        end
        if (bus.rsp_valid) begin
          check("rsp_result", 32'(bus.rsp_result), 32'(sb[0].res));
          check("rsp_mulh",   32'(bus.rsp_mulh),   32'(sb[0].mulh));
          check("rsp_flag",   32'(bus.rsp_flag),   32'(sb[0].flag));
          check("acc_q",      32'(bus.acc_q),      32'(sb[0].res));
          check("op_count",   32'(bus.op_count),   32'(sb[0].cnt));
          if (!bus.rsp_ready) check("ready_bp", 32'(bus.req_ready), 32'd0);
          else void'(sb.pop_front());
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        a_op   = bus.req_use_acc ? m_acc : bus.req_a;
        r      = alu_fn(bus.req_op, a_op, bus.req_b);
        e.res  = r[23:16];
        e.mulh = (bus.req_op == 3'd7) ? r[15:8] : 8'h00;
        e.flag = r[7:0];
        m_acc  = r[23:16];
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + CNT_W'(1);
        e.cnt   = m_cnt;
        e.stamp = cyc;
        e.seen  = 1'b0;
        sb.push_back(e);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    m_acc = ACC_INIT;
    m_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one request; returns at the negedge where its response is first visible
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic use_acc, input logic hold);
    bit ok;
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_use_acc = use_acc;
    bus.rsp_ready   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 3'($urandom_range(0, 7));
    bus.req_a       = 8'($urandom);
    bus.req_b       = 8'($urandom);
    bus.req_use_acc = 1'($urandom_range(0, 1));
    bus.rsp_ready   = ~hold;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_use_acc = 1'b0; bus.rsp_ready = 1'b1;
    apply_reset();
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_acc",       32'(bus.acc_q),     32'(ACC_INIT));
    check("rst_count",     32'(bus.op_count),  32'd0);
    check("rst_ready",     32'(bus.req_ready), 32'd1);
    check("rst_alu_s",     32'(bus.alu_s),     32'd0);

    // add without carry
    do_op(3'd5, 8'h3C, 8'h14, 1'b0, 1'b0);
    check("add_res",   32'(bus.rsp_result), 32'h50);
    check("add_carry", 32'(bus.rsp_flag[4]), 32'd0);
    check("add_mulh",  32'(bus.rsp_mulh),   32'd0);

    // full-scale multiply
    do_op(3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check("mul_res",  32'(bus.rsp_result), 32'h01);
    check("mul_mulh", 32'(bus.rsp_mulh),   32'hFE);

    // chain: held add, then sub from the accumulator accepted while in RESP
    do_op(3'd5, 8'h10, 8'h20, 1'b0, 1'b1);
    check("chain_add", 32'(bus.rsp_result), 32'h30);
    do_op(3'd6, 8'hEE, 8'h05, 1'b1, 1'b0);
    check("chain_sub",    32'(bus.rsp_result), 32'h2B);
    check("chain_acc",    32'(bus.acc_q),      32'h2B);
    check("chain_borrow", 32'(bus.rsp_flag[5]), 32'd1);

    // backpressure for 5 cycles, then release together with a new request
    do_op(3'd5, 8'hF0, 8'h20, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_result", 32'(bus.rsp_result), 32'h10);
      check("bp_carry",  32'(bus.rsp_flag[4]), 32'd1);
      check("bp_ready",  32'(bus.req_ready),  32'd0);
    end
    do_op(3'd3, 8'h81, 8'h01, 1'b0, 1'b0);
    check("bp_lsl", 32'(bus.rsp_result), 32'h02);

    // mixed traffic with random holds
    for (int i = 0; i < 12; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    do_op(3'd1, 8'h0F, 8'hF0, 1'b0, 1'b0);
    check("or_res", 32'(bus.rsp_result), 32'hFF);
    repeat (2) @(negedge clk);

    // mid-run reset, then the initial accumulator used as operand A
    @(posedge clk);
    #2;
    apply_reset();
    @(negedge clk);
    check("rst2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst2_acc",       32'(bus.acc_q),     32'(ACC_INIT));
    check("rst2_count",     32'(bus.op_count),  32'd0);
    check("rst2_ready",     32'(bus.req_ready), 32'd1);
    do_op(3'd0, 8'h00, 8'h3C, 1'b1, 1'b0);
    check("acc_init_and", 32'(bus.rsp_result), 32'h24);

    // reset while the op is executing: nothing may come out
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1; bus.req_op = 3'd5; bus.req_a = 8'h01; bus.req_b = 8'h02;
    bus.req_use_acc = 1'b0;
    @(negedge clk);
    check("exec_rst_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 apply_reset();
    repeat (6) @(negedge clk);
    check("exec_rst_count", 32'(bus.op_count),  32'd0);
    check("exec_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_rst_acc",   32'(bus.acc_q),     32'(ACC_INIT));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
